// File: rtl/uart_pkg.sv
// Shared UART definitions: baud/data-width constants and the transmit FSM states.
package uart_pkg;
  localparam int BAUD_9600_CLKS = 10417;
  localparam int UART_DATA_BITS = 8;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} uart_state_e;
endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO. Full and empty come from the occupancy count; head is read from
// the flop array, so it is valid the cycle after the entry is written.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic             do_push, do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  // Power-of-two depth lets the pointers wrap naturally.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end
endmodule

// File: rtl/uart_tx_fifo.sv
// Buffered 8N1 UART transmitter: byte FIFO feeding an LSB-first serialiser with
// back-to-back frames when data is waiting at the end of the stop period.
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = BAUD_9600_CLKS,
  parameter int FIFO_DEPTH   = 16,
  parameter int STOP_BITS    = 1
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [UART_DATA_BITS-1:0]     tx_data,
  input  logic                          tx_valid,
  output logic                          tx_ready,
  output logic                          uart_tx,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);
  localparam int            BW        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
  localparam logic [2:0]    DATA_LAST = 3'(UART_DATA_BITS - 1);
  localparam logic [2:0]    STOP_LAST = 3'(STOP_BITS - 1);

  uart_state_e               state, state_n;
  logic [BW-1:0]             baud, baud_n;
  logic [2:0]                bit_idx, bit_n;
  logic [UART_DATA_BITS-1:0] shift, shift_n;
  logic [UART_DATA_BITS-1:0] head;
  logic                      full, empty, pop, line;

  sync_fifo #(.WIDTH(UART_DATA_BITS), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (tx_valid),
    .pop   (pop),
    .din   (tx_data),
    .head  (head),
    .full  (full),
    .empty (empty),
    .count (fifo_count)
  );

  // full is decoded from the registered count, so a same-cycle pop never opens the door.
  assign tx_ready = !full;

  always_comb begin
    state_n = state;
    baud_n  = baud;
    bit_n   = bit_idx;
    shift_n = shift;
    pop     = 1'b0;
    case (state)
      IDLE: begin
        if (!empty) begin
          shift_n = head;
          pop     = 1'b1;
          baud_n  = '0;
          state_n = START;
        end
      end
      START: begin
        if (baud == BAUD_LAST) begin
          baud_n  = '0;
          bit_n   = '0;
          state_n = DATA;
        end else begin
          baud_n = baud + BW'(1);
        end
      end
      DATA: begin
        if (baud == BAUD_LAST) begin
          baud_n  = '0;
          shift_n = shift >> 1;
          if (bit_idx == DATA_LAST) begin
            bit_n   = '0;
            state_n = STOP;
          end else begin
            bit_n = bit_idx + 3'd1;
          end
        end else begin
          baud_n = baud + BW'(1);
        end
      end
      STOP: begin
        if (baud == BAUD_LAST) begin
          baud_n = '0;
          if (bit_idx == STOP_LAST) begin
            bit_n = '0;
            // Chain straight into the next start bit when data is waiting.
            if (!empty) begin
              shift_n = head;
              pop     = 1'b1;
              state_n = START;
            end else begin
              state_n = IDLE;
            end
          end else begin
            bit_n = bit_idx + 3'd1;
          end
        end else begin
          baud_n = baud + BW'(1);
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    line = 1'b1;
    case (state)
      START:   line = 1'b0;
      DATA:    line = shift[0];
      default: line = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      baud    <= '0;
      bit_idx <= '0;
      shift   <= '0;
      uart_tx <= 1'b1;
      busy    <= 1'b0;
    end else begin
      state   <= state_n;
      baud    <= baud_n;
      bit_idx <= bit_n;
      shift   <= shift_n;
      uart_tx <= line;
      busy    <= (state != IDLE) || (fifo_count != '0);
    end
  end
endmodule
